// File: rtl/synapse_accumulator_pkg.sv
// Shared definitions for the synapse accumulator and neighbouring neuron stages:
// FSM state type, index-width helper and a saturating adder.
package synapse_accumulator_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int unsigned SAT_MAX_W = 64;

  function automatic int unsigned idx_width(input int unsigned num_syn);
    return $clog2(num_syn);
  endfunction

  // Unsigned add clamped to 2^width-1; operands must fit comfortably below 2^64.
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                    input logic [SAT_MAX_W-1:0] b,
                                                    input int unsigned width);
    logic [SAT_MAX_W-1:0] sum;
    logic [SAT_MAX_W-1:0] limit;
    sum   = a + b;
    limit = (64'd1 << width) - 64'd1;
    if (sum > limit) begin
      return limit;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/synapse_accumulator_weight_regfile.sv
// Synaptic weight storage: one write port, one combinational read port,
// cleared by synchronous reset.
module synapse_weight_regfile #(
  parameter int unsigned NUM_SYN      = 16,
  parameter int unsigned WEIGHT_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_we,
  input  logic [$clog2(NUM_SYN)-1:0] i_waddr,
  input  logic [WEIGHT_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(NUM_SYN)-1:0] i_raddr,
  output logic [WEIGHT_WIDTH-1:0]    o_rdata
);

  logic [WEIGHT_WIDTH-1:0] weights_q [NUM_SYN];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NUM_SYN); i++) begin
        weights_q[i] <= {WEIGHT_WIDTH{1'b0}};
      end
    end else if (i_we) begin
      weights_q[i_waddr] <= i_wdata;
    end
  end

  // Read happens before any same-edge write lands, so a scan sees the old weight.
  assign o_rdata = weights_q[i_raddr];

endmodule

// File: rtl/synapse_accumulator.sv
// Serial weighted-sum stage: scans one synapse per clock and emits a single
// saturated contribution word per frame for the downstream neuron.
module synapse_accumulator
  import synapse_accumulator_pkg::*;
#(
  parameter int unsigned DATA_LENGTH  = 32,
  parameter int unsigned NUM_SYN      = 16,
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned WEIGHT_SHIFT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_SYN-1:0]         i_pre_spike,
  input  logic                       i_pre_valid,
  output logic                       o_pre_ready,
  input  logic                       i_w_we,
  input  logic [$clog2(NUM_SYN)-1:0] i_w_addr,
  input  logic [WEIGHT_WIDTH-1:0]    i_w_data,
  output logic [DATA_LENGTH-1:0]     o_spike,
  output logic                       o_frame_done,
  output logic                       o_overrun
);

  localparam int unsigned IDX_W = idx_width(NUM_SYN);
  localparam int unsigned ACC_W = DATA_LENGTH + IDX_W + 1;

  state_e                 state_q,   state_d;
  logic [IDX_W-1:0]       idx_q,     idx_d;
  logic [ACC_W-1:0]       acc_q,     acc_d;
  logic [NUM_SYN-1:0]     spikes_q,  spikes_d;
  logic [DATA_LENGTH-1:0] spike_q,   spike_d;
  logic                   done_q,    done_d;
  logic                   overrun_q, overrun_d;

  logic [WEIGHT_WIDTH-1:0] weight_s;
  logic [ACC_W-1:0]        term_s;

  synapse_weight_regfile #(
    .NUM_SYN      (NUM_SYN),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_weights (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (i_w_we),
    .i_waddr (i_w_addr),
    .i_wdata (i_w_data),
    .i_raddr (idx_q),
    .o_rdata (weight_s)
  );

  assign term_s = spikes_q[idx_q]
                ? ({{(ACC_W-WEIGHT_WIDTH){1'b0}}, weight_s} << WEIGHT_SHIFT)
                : {ACC_W{1'b0}};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    spikes_d  = spikes_q;
    spike_d   = {DATA_LENGTH{1'b0}};
    done_d    = 1'b0;
    overrun_d = overrun_q | (i_pre_valid & (state_q == SCAN));
    case (state_q)
      IDLE: begin
        if (i_pre_valid) begin
          spikes_d = i_pre_spike;
          acc_d    = {ACC_W{1'b0}};
          idx_d    = {IDX_W{1'b0}};
          state_d  = SCAN;
        end else begin
          state_d  = IDLE;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_SYN - 1)) begin
          spike_d = DATA_LENGTH'(sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(term_s), DATA_LENGTH));
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          acc_d   = acc_q + term_s;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      idx_q     <= {IDX_W{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      spikes_q  <= {NUM_SYN{1'b0}};
      spike_q   <= {DATA_LENGTH{1'b0}};
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      spikes_q  <= spikes_d;
      spike_q   <= spike_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_pre_ready  = (state_q == IDLE);
  assign o_spike      = spike_q;
  assign o_frame_done = done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed plus randomized bench for synapse_accumulator, checked against a
// sum-of-weights reference model.
module tb_synapse_accumulator;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_pre_spike;
  logic        i_pre_valid;
  logic        o_pre_ready;
  logic        i_w_we;
  logic [3:0]  i_w_addr;
  logic [15:0] i_w_data;
  logic [31:0] o_spike;
  logic        o_frame_done;
  logic        o_overrun;

  int tests = 0;
  int fails = 0;
  logic [15:0] w_m [16];

  synapse_accumulator dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pre_spike  (i_pre_spike),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .i_w_we       (i_w_we),
    .i_w_addr     (i_w_addr),
    .i_w_data     (i_w_data),
    .o_spike      (o_spike),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sum of selected weights scaled by 2^16, clamped to 32 bits.
  function automatic logic [31:0] model(input logic [15:0] sp);
    longint unsigned s = 0;
    for (int i = 0; i < 16; i++) begin
      if (sp[i]) s += longint'(w_m[i]) * 65536;
    end
    if (s > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return s[31:0];
  endfunction

  task automatic write_w(input logic [3:0] a, input logic [15:0] d);
    i_w_we = 1'b1; i_w_addr = a; i_w_data = d;
    @(negedge i_clk);
    i_w_we = 1'b0;
    w_m[a] = d;
  endtask

  task automatic do_frame(input logic [15:0] sp, input logic [31:0] exp, input string tag,
                          input int wr_at, input logic [3:0] wa, input logic [15:0] wd);
    int n;
    bit seen;
    chk({tag, "_ready"}, o_pre_ready, 1);
    i_pre_spike = sp; i_pre_valid = 1'b1;
    @(negedge i_clk);
    i_pre_valid = 1'b0;
    n = 0; seen = 0;
    while (n < 40 && !seen) begin
      if (n == wr_at) begin
        i_w_we = 1'b1; i_w_addr = wa; i_w_data = wd;
      end else begin
        i_w_we = 1'b0;
      end
      @(negedge i_clk);
      n++;
      if (o_frame_done) seen = 1;
      else chk({tag, "_zero_idle"}, o_spike, 0);
    end
    i_w_we = 1'b0;
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_latency"}, n, 16);
    chk({tag, "_value"}, o_spike, exp);
    @(negedge i_clk);
    chk({tag, "_done_1cyc"}, o_frame_done, 0);
    chk({tag, "_spike_after"}, o_spike, 0);
  endtask

  initial begin
    int n, last, pulses, dones;
    logic [15:0] sp;
    i_rst = 1'b1; i_pre_spike = 16'h0; i_pre_valid = 1'b0;
    i_w_we = 1'b0; i_w_addr = 4'h0; i_w_data = 16'h0;
    for (int i = 0; i < 16; i++) w_m[i] = 16'h0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_spike", o_spike, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_ready", o_pre_ready, 1);
    i_rst = 1'b0;

    for (int i = 0; i < 16; i++) write_w(4'(i), 16'h0100);
    do_frame(16'h000F, model(16'h000F), "basic", -1, 4'h0, 16'h0);
    chk("basic_const", model(16'h000F), 32'h0400_0000);

    for (int i = 0; i < 16; i++) write_w(4'(i), 16'hFFFF);
    do_frame(16'hFFFF, model(16'hFFFF), "sat", -1, 4'h0, 16'h0);
    do_frame(16'h0001, model(16'h0001), "one", -1, 4'h0, 16'h0);

    // Continuous valid: a frame every 17 cycles, overrun flagged while busy.
    write_w(4'h0, 16'h0001);
    i_pre_spike = 16'h0001; i_pre_valid = 1'b1;
    @(negedge i_clk);
    chk("ovr_at_accept", o_overrun, 0);
    @(negedge i_clk);
    chk("ovr_busy", o_overrun, 1);
    n = 1; last = -1; pulses = 0;
    while (pulses < 3 && n < 100) begin
      @(negedge i_clk);
      n++;
      if (o_frame_done) begin
        chk("cont_value", o_spike, model(16'h0001));
        if (last >= 0) chk("cont_period", n - last, 17);
        last = n;
        pulses++;
        if (pulses == 3) i_pre_valid = 1'b0;
      end
    end
    chk("cont_pulses", pulses, 3);
    @(negedge i_clk);
    chk("cont_ovr_sticky", o_overrun, 1);
    chk("cont_idle_ready", o_pre_ready, 1);

    // Weight write landing on the edge that scans idx 5.
    for (int i = 0; i < 16; i++) write_w(4'(i), 16'h0100);
    do_frame(16'h0020, model(16'h0020), "wr_edge", 5, 4'h5, 16'h0200);
    w_m[5] = 16'h0200;
    do_frame(16'h0020, model(16'h0020), "wr_after", -1, 4'h0, 16'h0);

    // Reset mid-scan.
    i_pre_spike = 16'hFFFF; i_pre_valid = 1'b1;
    @(negedge i_clk);
    i_pre_valid = 1'b0;
    for (int k = 0; k < 7; k++) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 16; i++) w_m[i] = 16'h0;
    chk("midrst_ready", o_pre_ready, 1);
    chk("midrst_overrun", o_overrun, 0);
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge i_clk);
      if (o_frame_done || o_spike != 32'h0) dones++;
    end
    chk("midrst_silent", dones, 0);
    do_frame(16'hFFFF, model(16'hFFFF), "midrst_wzero", -1, 4'h0, 16'h0);

    // Reset and valid together: frame refused.
    write_w(4'h3, 16'h1234);
    i_rst = 1'b1; i_pre_valid = 1'b1; i_pre_spike = 16'hFFFF;
    @(negedge i_clk);
    i_rst = 1'b0; i_pre_valid = 1'b0;
    for (int i = 0; i < 16; i++) w_m[i] = 16'h0;
    chk("rstvalid_ready", o_pre_ready, 1);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_frame_done) dones++;
    end
    chk("rstvalid_nodone", dones, 0);

    for (int i = 0; i < 16; i++) write_w(4'(i), 16'h0100);
    do_frame(16'h0000, model(16'h0000), "zero", -1, 4'h0, 16'h0);

    // Randomized weights and frames.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 3; k++) begin
        write_w(4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      end
      sp = 16'($urandom);
      do_frame(sp, model(sp), "rand", -1, 4'h0, 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
